// File: rtl/loop_sequencer.sv
// loop_sequencer: three-level nested loop index generator with stall, abort and done handshake
module loop_sequencer #(
    parameter int BIT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [BIT_WIDTH-1:0] cfg_max_i,
    input  logic [BIT_WIDTH-1:0] cfg_max_j,
    input  logic [BIT_WIDTH-1:0] cfg_max_k,
    input  logic                 stall,
    output logic [BIT_WIDTH-1:0] idx_i,
    output logic [BIT_WIDTH-1:0] idx_j,
    output logic [BIT_WIDTH-1:0] idx_k,
    output logic                 valid,
    output logic                 first_k,
    output logic                 last,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    logic [BIT_WIDTH-1:0] max_i, max_j, max_k;
    logic                 k_wrap, j_wrap;

    assign k_wrap  = idx_k == max_k;
    assign j_wrap  = idx_j == max_j;
    assign valid   = state == RUN;
    assign busy    = state != IDLE;
    assign done    = state == DONE;
    assign first_k = valid && idx_k == '0;
    assign last    = valid && k_wrap && j_wrap && idx_i == max_i;

    // State, latched bounds and indices; wrap happens at the latched max so increments never overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx_i <= '0;
            idx_j <= '0;
            idx_k <= '0;
            max_i <= '0;
            max_j <= '0;
            max_k <= '0;
        end else if (state == IDLE) begin
            if (start && !abort) begin
                state <= RUN;
                max_i <= cfg_max_i;
                max_j <= cfg_max_j;
                max_k <= cfg_max_k;
                idx_i <= '0;
                idx_j <= '0;
                idx_k <= '0;
            end
        end else if (state == DONE || abort) begin
            state <= IDLE;
            idx_i <= '0;
            idx_j <= '0;
            idx_k <= '0;
        end else if (!stall) begin
            state <= last ? DONE : RUN;
            idx_k <= (k_wrap || last) ? '0 : idx_k + 1'b1;
            idx_j <= (last || (k_wrap && j_wrap)) ? '0 : k_wrap ? idx_j + 1'b1 : idx_j;
            idx_i <= last ? '0 : (k_wrap && j_wrap) ? idx_i + 1'b1 : idx_i;
        end
    end
endmodule

// File: tb/tb_loop_sequencer.sv
// tb_loop_sequencer: randomized self-checking bench against a queue-of-beats reference model
module tb_loop_sequencer;
    localparam int W = 5;

    typedef struct packed {
        logic [W-1:0] i;
        logic [W-1:0] j;
        logic [W-1:0] k;
    } beat_t;

    logic         clk = 0;
    logic         rst, start, abort, stall;
    logic [W-1:0] cfg_max_i, cfg_max_j, cfg_max_k;
    logic [W-1:0] idx_i, idx_j, idx_k;
    logic         valid, first_k, last, busy, done;
    int           total = 0;
    int           bad = 0;
    beat_t        q[$];

    loop_sequencer #(.BIT_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_max_i(cfg_max_i), .cfg_max_j(cfg_max_j), .cfg_max_k(cfg_max_k),
        .stall(stall), .idx_i(idx_i), .idx_j(idx_j), .idx_k(idx_k),
        .valid(valid), .first_k(first_k), .last(last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] outs();
        return 64'({busy, valid, done, first_k, last, idx_i, idx_j, idx_k});
    endfunction

    function automatic logic [63:0] expect_out(logic b, logic v, logic d, logic f, logic l, beat_t x);
        return 64'({b, v, d, f, l, x});
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_cfg();
        cfg_max_i = W'($urandom);
        cfg_max_j = W'($urandom);
        cfg_max_k = W'($urandom);
    endtask

    // Starts a nest and checks every cycle against the expected beat list.
    // kill>0 aborts (or resets, with start held) during that cycle instead of finishing.
    task automatic run_nest(int mi, int mj, int mk, int rate, logic [63:0] mask, int kill, bit use_rst);
        int cyc;
        q.delete();
        for (int a = 0; a <= mi; a++)
            for (int b = 0; b <= mj; b++)
                for (int c = 0; c <= mk; c++)
                    q.push_back(beat_t'({W'(a), W'(b), W'(c)}));
        cfg_max_i = W'(mi);
        cfg_max_j = W'(mj);
        cfg_max_k = W'(mk);
        start = 1;
        abort = 0;
        stall = 0;
        tick();
        cyc = 1;
        while (q.size() > 0) begin
            if (cyc > 5000) begin
                check("timeout", 64'(q.size()), 64'(0));
                break;
            end
            check("beat", outs(), expect_out(1, 1, 0, q[0].k == '0, q.size() == 1, q[0]));
            if (cyc == kill) begin
                abort = !use_rst;
                rst = use_rst;
                start = 1;
                stall = 1'($urandom);
                tick();
                rst = 0;
                abort = 0;
                start = 0;
                q.delete();
                check(use_rst ? "rst_kill" : "abort_kill", outs(), 64'(0));
                for (int n = 0; n < 3; n++) begin
                    tick();
                    check("killed_idle", outs(), 64'(0));
                end
                return;
            end
            stall = (cyc < 64 ? mask[cyc] : 1'b0) || ($urandom_range(99) < rate);
            start = 1'($urandom);
            randomize_cfg();
            if (!stall) void'(q.pop_front());
            tick();
            cyc++;
        end
        check("done", outs(), expect_out(1, 0, 1, 0, 0, '0));
        start = 1'($urandom);
        stall = 1'($urandom);
        tick();
        check("after_done", outs(), 64'(0));
        start = 0;
        stall = 0;
    endtask

    initial begin
        rst = 1;
        start = 1;
        abort = 0;
        stall = 1;
        randomize_cfg();
        tick();
        check("reset0", outs(), 64'(0));
        tick();
        check("reset1", outs(), 64'(0));
        rst = 0;
        start = 1;
        abort = 1;
        tick();
        check("abort_over_start", outs(), 64'(0));
        abort = 0;
        start = 0;
        tick();
        check("idle", outs(), 64'(0));
        run_nest(1, 1, 2, 0, 64'd0, 0, 0);
        run_nest(0, 0, 3, 0, 64'b1100, 0, 0);
        run_nest(0, 0, 0, 0, 64'd0, 0, 0);
        run_nest(1, 1, 1, 0, 64'd0, 3, 0);
        run_nest(1, 1, 1, 0, 64'd0, 0, 0);
        run_nest(2, 2, 2, 30, 64'd0, 5, 1);
        run_nest(2, 1, 2, 30, 64'd0, 0, 0);
        run_nest(0, 0, 31, 20, 64'd0, 0, 0);
        run_nest(31, 0, 0, 0, 64'd0, 0, 0);
        run_nest(0, 31, 1, 10, 64'd0, 0, 0);
        for (int r = 0; r < 8; r++)
            run_nest(int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(3)),
                     int'($urandom_range(60)), 64'd0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/loop_sequencer.md
LOOP_SEQUENCER -- requirements
Module: loop_sequencer

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 5, the width of every loop bound and index.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to begin a new loop nest; accepted only in IDLE.
REQ-005 SHALL have port abort, input, 1, terminates an in-progress nest without done.
REQ-006 SHALL have port cfg_max_i, input, BIT_WIDTH, inclusive final value of outer index i.
REQ-007 SHALL have port cfg_max_j, input, BIT_WIDTH, inclusive final value of middle index j.
REQ-008 SHALL have port cfg_max_k, input, BIT_WIDTH, inclusive final value of inner index k.
REQ-009 SHALL have port stall, input, 1, downstream not ready; the current beat is held.
REQ-010 SHALL have port idx_i, idx_j, idx_k, output, BIT_WIDTH each, current loop indices.
REQ-011 SHALL have port valid, output, 1, indices are a live beat (high exactly in RUN).
REQ-012 SHALL have port first_k, output, 1, valid && idx_k==0 (accumulator-clear hint).
REQ-013 SHALL have port last, output, 1, valid && all indices equal their latched max.
REQ-014 SHALL have port busy, output, 1, state != IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse after the final beat is accepted.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered or decoded from registers only, no input-to-output combinational path except none (stall does not affect outputs same cycle).
REQ-017 SHALL, in IDLE with start=1 and abort=0, latch cfg_max_i/j/k into internal registers, clear indices to 0, and enter RUN next cycle.
REQ-018 SHALL ignore cfg_max_* changes after the latching cycle until the next accepted start.
REQ-019 SHALL define an accepted beat as valid && !stall; indices advance only on accepted beats.
REQ-020 SHALL advance as nested counters: k increments; when k==max_k, k wraps to 0 and j increments; when j==max_j also, j wraps to 0 and i increments.
REQ-021 SHALL, on an accepted beat with last=1, zero all indices and enter DONE next cycle.
REQ-022 SHALL hold indices, valid and state unchanged while stall=1 in RUN.
REQ-023 SHALL assert done=1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-024 SHALL ignore start in RUN and DONE (no relatch, no restart).
REQ-025 SHALL, on abort=1 in RUN or DONE, enter IDLE next cycle with indices zeroed and no done pulse; abort in DONE suppresses nothing already driven that cycle.
REQ-026 SHALL give abort priority over start when both are high in IDLE (stay IDLE).
REQ-027 SHALL produce exactly (max_i+1)*(max_j+1)*(max_k+1) accepted beats per nest, in lexicographic (i,j,k) order, none skipped or repeated.
REQ-028 SHALL treat all maxima of 0 as a single-beat nest (first_k=1 and last=1 on that beat).
REQ-029 SHALL compute index increments at BIT_WIDTH with no overflow possible, since wrap occurs at the latched max (max of 2^BIT_WIDTH-1 is legal).

Reset
REQ-030 SHALL, when rst=1 at a rising edge, enter IDLE and clear indices, latched maxima, valid, first_k, last, busy and done to 0, overriding start, abort and stall.
REQ-031 SHALL honor rst mid-RUN: next cycle is IDLE, no done pulse.

Verification
REQ-032 SHALL cover max=(1,1,2), stall=0, start at cycle 0 -> valid cycles 1..12, order (0,0,0)..(1,1,2), first_k on cycles 1,4,7,10, last on cycle 12, done on cycle 13, busy cycles 1..13.
REQ-033 SHALL cover max=(0,0,3), stall high on cycles 2-3 -> idx_k=1 held cycles 2-4, last on cycle 6, done cycle 7.
REQ-034 SHALL cover max=(0,0,0) -> single beat cycle 1 with first_k=last=1, done cycle 2.
REQ-035 SHALL cover abort at (0,1,0) of max=(1,1,1) -> IDLE next cycle, indices 0, done never asserts; a following start runs a full 8-beat nest.
REQ-036 SHALL cover start pulsed in RUN with different cfg_max_* -> original maxima continue, beat count unchanged.
REQ-037 SHALL cover rst asserted mid-RUN with start=1 held -> all outputs 0 the next cycle, IDLE; RUN resumes only on a start sampled with rst=0.
